// File: rtl/jfpjc_pkg.sv
// ============================================================================
// Module   : jfpjc_pkg
// Brief    : Shared types and constants for the JPEG stream framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jfpjc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HEADER   = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_TRAIL_FF = 3'd3,
      ST_TRAIL_D9 = 3'd4
   } framer_state_t;

   localparam logic [7:0] JPEG_EOI_HI = 8'hFF;
   localparam logic [7:0] JPEG_EOI_LO = 8'hD9;

   localparam int DEFAULT_HEADER_LEN   = 328;
   localparam int DEFAULT_QUANT_OFFSET = 25;
   localparam int DEFAULT_QUANT_LEN    = 64;

endpackage

`default_nettype wire

// File: rtl/jfpjc_byte_fifo.sv
// ============================================================================
// Module   : jfpjc_byte_fifo
// Brief    : Synchronous first-word-fall-through byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jfpjc_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clock,
   input  logic       nreset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [7:0]  r_mem [DEPTH];
   logic        w_do_push;
   logic        w_do_pop;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_do_push = push && (!full || pop);
   assign w_do_pop  = pop && !empty;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign dout  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/jpeg_stream_framer.sv
// ============================================================================
// Module   : jpeg_stream_framer
// Brief    : Wraps compressor payload bytes into a JFIF stream (header, payload, EOI).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_stream_framer
   import jfpjc_pkg::*;
#(
   parameter int HEADER_LEN   = DEFAULT_HEADER_LEN,
   parameter int QUANT_OFFSET = DEFAULT_QUANT_OFFSET,
   parameter int QUANT_LEN    = DEFAULT_QUANT_LEN,
   parameter int HDR_ADDR_W   = 9,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  frame_start,
   input  logic                  frame_end,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic [HDR_ADDR_W-1:0] header_ebr_raddr,
   output logic                  header_ebr_ren,
   input  logic [7:0]            header_ebr_dout,
   output logic [5:0]            quant_ebr_raddr,
   output logic                  quant_ebr_ren,
   input  logic [7:0]            quant_ebr_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_data,
   output logic                  out_sof,
   output logic                  out_eof,
   output logic                  overflow,
   output logic                  frame_error
);

   localparam int IDX_W = $clog2(HEADER_LEN + 1);
   localparam logic [IDX_W-1:0] c_hdr_len = IDX_W'(HEADER_LEN);
   localparam logic [IDX_W-1:0] c_q_lo    = IDX_W'(QUANT_OFFSET);
   localparam logic [IDX_W-1:0] c_q_hi    = IDX_W'(QUANT_OFFSET + QUANT_LEN);

   framer_state_t    r_state;
   logic [IDX_W-1:0] r_rd_idx;
   logic             r_pend;
   logic             r_pend_quant;
   logic             r_skid_valid;
   logic [7:0]       r_skid_data;
   logic             r_first;
   logic             r_end_pending;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic             r_out_sof;
   logic             r_out_eof;
   logic             r_overflow;
   logic             r_frame_error;

   logic             w_can_load;
   logic             w_active;
   logic             w_in_quant;
   logic             w_rd_more;
   logic             w_ren;
   logic [7:0]       w_pend_data;
   logic             w_hdr_done;
   logic             w_fifo_push;
   logic             w_fifo_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [7:0]       w_fifo_dout;
   logic             w_drop;

   assign w_can_load  = !r_out_valid || out_ready;
   assign w_active    = (r_state != ST_IDLE);
   assign w_in_quant  = (r_rd_idx >= c_q_lo) && (r_rd_idx < c_q_hi);
   assign w_rd_more   = (r_rd_idx < c_hdr_len);
   assign w_ren       = (r_state == ST_HEADER) && w_rd_more && w_can_load;
   assign w_pend_data = r_pend_quant ? quant_ebr_dout : header_ebr_dout;
   assign w_hdr_done  = !w_rd_more && !r_pend && !r_skid_valid && w_can_load;

   assign w_fifo_pop  = (r_state == ST_PAYLOAD) && w_can_load && !w_fifo_empty;
   assign w_fifo_push = in_valid && w_active && (!w_fifo_full || w_fifo_pop);
   assign w_drop      = in_valid && w_active && w_fifo_full && !w_fifo_pop;

   assign header_ebr_ren   = w_ren && !w_in_quant;
   assign quant_ebr_ren    = w_ren && w_in_quant;
   assign header_ebr_raddr = w_in_quant ? '0 : HDR_ADDR_W'(r_rd_idx);
   assign quant_ebr_raddr  = w_in_quant ? 6'(r_rd_idx - c_q_lo) : 6'd0;

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_sof     = r_out_sof;
   assign out_eof     = r_out_eof;
   assign overflow    = r_overflow;
   assign frame_error = r_frame_error;

   jfpjc_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .nreset (nreset),
      .push   (w_fifo_push),
      .pop    (w_fifo_pop),
      .din    (in_data),
      .dout   (w_fifo_dout),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_state       <= ST_IDLE;
         r_rd_idx      <= '0;
         r_pend        <= 1'b0;
         r_pend_quant  <= 1'b0;
         r_skid_valid  <= 1'b0;
         r_skid_data   <= 8'h00;
         r_first       <= 1'b0;
         r_end_pending <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= 8'h00;
         r_out_sof     <= 1'b0;
         r_out_eof     <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_pend       <= w_ren;
         r_pend_quant <= w_in_quant;
         if (w_ren) r_rd_idx <= r_rd_idx + IDX_W'(1);
         if (w_drop) r_overflow <= 1'b1;
         if (w_active && frame_start) r_frame_error <= 1'b1;
         if (w_active && frame_end) r_end_pending <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (frame_start) begin
                  r_state       <= ST_HEADER;
                  r_rd_idx      <= '0;
                  r_first       <= 1'b1;
                  r_skid_valid  <= 1'b0;
                  r_overflow    <= 1'b0;
                  r_frame_error <= 1'b0;
                  r_end_pending <= 1'b0;
               end
            end

            ST_HEADER: begin
               // A read that lands while the output is stalled parks in the skid
               // register; no new read is issued until it has been consumed.
               if (w_can_load) begin
                  r_out_eof <= 1'b0;
                  if (r_skid_valid) begin
                     r_out_valid  <= 1'b1;
                     r_out_data   <= r_skid_data;
                     r_out_sof    <= r_first;
                     r_first      <= 1'b0;
                     r_skid_valid <= 1'b0;
                  end else if (r_pend) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_pend_data;
                     r_out_sof   <= r_first;
                     r_first     <= 1'b0;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_out_sof   <= 1'b0;
                  end
               end else if (r_pend) begin
                  r_skid_valid <= 1'b1;
                  r_skid_data  <= w_pend_data;
               end
               if (w_hdr_done) r_state <= ST_PAYLOAD;
            end

            ST_PAYLOAD: begin
               if (w_can_load) begin
                  r_out_sof <= 1'b0;
                  r_out_eof <= 1'b0;
                  if (!w_fifo_empty) begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_fifo_dout;
                  end else begin
                     r_out_valid <= 1'b0;
                     if (r_end_pending) r_state <= ST_TRAIL_FF;
                  end
               end
            end

            ST_TRAIL_FF: begin
               if (w_can_load) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= JPEG_EOI_HI;
                  r_out_sof   <= 1'b0;
                  r_out_eof   <= 1'b0;
                  r_state     <= ST_TRAIL_D9;
               end
            end

            ST_TRAIL_D9: begin
               if (r_out_valid && r_out_eof) begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     r_out_eof   <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end else if (w_can_load) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= JPEG_EOI_LO;
                  r_out_sof   <= 1'b0;
                  r_out_eof   <= 1'b1;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jpeg_stream_framer.sv
// ============================================================================
// Module   : tb_jpeg_stream_framer
// Brief    : Scoreboard bench for jpeg_stream_framer with ROM models of both EBRs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeg_stream_framer;

   localparam int HL = 328;
   localparam int QO = 25;
   localparam int QL = 64;
   localparam int AW = 9;
   localparam int FD = 16;

   logic          clock = 1'b0;
   logic          nreset = 1'b0;
   logic          frame_start = 1'b0;
   logic          frame_end = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic [AW-1:0] header_ebr_raddr;
   logic          header_ebr_ren;
   logic [7:0]    header_ebr_dout = 8'h00;
   logic [5:0]    quant_ebr_raddr;
   logic          quant_ebr_ren;
   logic [7:0]    quant_ebr_dout = 8'h00;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic          out_sof;
   logic          out_eof;
   logic          overflow;
   logic          frame_error;

   logic          tog_en = 1'b0;
   logic          tog = 1'b0;
   logic          rdy_level = 1'b1;
   assign out_ready = tog_en ? tog : rdy_level;

   logic [9:0]    sb[$];
   int            n_vec = 0;
   int            n_err = 0;

   always #5 clock = ~clock;

   jpeg_stream_framer #(
      .HEADER_LEN   (HL),
      .QUANT_OFFSET (QO),
      .QUANT_LEN    (QL),
      .HDR_ADDR_W   (AW),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clock            (clock),
      .nreset           (nreset),
      .frame_start      (frame_start),
      .frame_end        (frame_end),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .header_ebr_raddr (header_ebr_raddr),
      .header_ebr_ren   (header_ebr_ren),
      .header_ebr_dout  (header_ebr_dout),
      .quant_ebr_raddr  (quant_ebr_raddr),
      .quant_ebr_ren    (quant_ebr_ren),
      .quant_ebr_dout   (quant_ebr_dout),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_sof          (out_sof),
      .out_eof          (out_eof),
      .overflow         (overflow),
      .frame_error      (frame_error)
   );

   // ROM contents: header = low 8 bits of the address, quant = 8'h80 + address.
   always_ff @(posedge clock) begin
      if (header_ebr_ren) header_ebr_dout <= header_ebr_raddr[7:0];
      if (quant_ebr_ren)  quant_ebr_dout  <= 8'h80 + {2'b00, quant_ebr_raddr};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_header();
      logic [7:0] d;
      for (int i = 0; i < HL; i++) begin
         if (i >= QO && i < QO + QL) d = 8'h80 + 8'(i - QO);
         else                        d = 8'(i);
         sb.push_back({1'b0, (i == 0), d});
      end
   endtask

   task automatic expect_payload(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) sb.push_back({2'b00, base + 8'(i)});
   endtask

   task automatic expect_trailer();
      sb.push_back({2'b00, 8'hFF});
      sb.push_back({2'b10, 8'hD9});
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic pulse_end();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic push_bytes(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = base + 8'(i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int max, input string name);
      int c;
      c = 0;
      while ((sb.size() != 0 || out_valid) && c < max) begin
         tick();
         c++;
      end
      check(name, sb.size(), 0);
   endtask

   task automatic monitor();
      logic       hv;
      logic [9:0] hd;
      logic [9:0] got;
      logic [9:0] exp;
      hv = 1'b0;
      hd = '0;
      forever begin
         @(negedge clock);
         if (!nreset) begin
            hv = 1'b0;
         end else begin
            got = {out_eof, out_sof, out_data};
            if (hv) begin
               check("hold_valid", {31'b0, out_valid}, 32'd1);
               if (out_valid) check("hold_data", {22'b0, got}, {22'b0, hd});
            end
            if (!out_valid && (out_sof || out_eof))
               check("flag_without_valid", {30'b0, out_eof, out_sof}, 32'd0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL extra_byte: got %0h expected none at %0t", got, $time);
               end else begin
                  exp = sb.pop_front();
                  check("byte", {22'b0, got}, {22'b0, exp});
               end
            end
            hv = out_valid && !out_ready;
            hd = got;
         end
      end
   endtask

   task automatic toggler();
      forever begin
         @(posedge clock);
         #1;
         tog = ~tog;
      end
   endtask

   initial begin
      fork
         monitor();
         toggler();
      join_none

      // Reset state
      repeat (3) tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", {24'b0, out_data}, 32'd0);
      check("rst_sof_eof", {30'b0, out_sof, out_eof}, 32'd0);
      check("rst_sticky", {30'b0, overflow, frame_error}, 32'd0);
      check("rst_ren", {30'b0, header_ebr_ren, quant_ebr_ren}, 32'd0);
      check("rst_raddr", {17'b0, header_ebr_raddr, quant_ebr_raddr}, 32'd0);
      nreset = 1'b1;
      tick();

      // Frame 1: header only, latency to first byte
      expect_header();
      expect_trailer();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("lat_cycle1", {31'b0, out_valid}, 32'd0);
      tick();
      check("lat_cycle2", {31'b0, out_valid}, 32'd0);
      tick();
      check("first_valid_latency", {31'b0, out_valid}, 32'd1);
      pulse_end();
      drain(1000, "frame1_drain");

      // Frame 2: ten payload bytes during the header
      expect_header();
      expect_payload(8'hA0, 10);
      expect_trailer();
      pulse_start();
      push_bytes(8'hA0, 10);
      pulse_end();
      drain(1000, "frame2_drain");

      // Frame 3: alternating backpressure
      tog_en = 1'b1;
      expect_header();
      expect_payload(8'hB0, 5);
      expect_trailer();
      pulse_start();
      repeat (3) tick();
      push_bytes(8'hB0, 5);
      pulse_end();
      drain(3000, "frame3_drain");
      tog_en = 1'b0;

      // Frame 4: sink stalled, FIFO overrun by two bytes
      rdy_level = 1'b0;
      expect_header();
      expect_payload(8'hC0, FD);
      expect_trailer();
      pulse_start();
      push_bytes(8'hC0, FD + 2);
      check("overflow_set", {31'b0, overflow}, 32'd1);
      check("no_frame_error", {31'b0, frame_error}, 32'd0);
      pulse_end();
      rdy_level = 1'b1;
      drain(1000, "frame4_drain");
      check("overflow_sticky", {31'b0, overflow}, 32'd1);

      // Frame 5: frame_start while in PAYLOAD
      expect_header();
      expect_payload(8'hE0, 3);
      expect_trailer();
      pulse_start();
      check("overflow_cleared", {31'b0, overflow}, 32'd0);
      push_bytes(8'hE0, 3);
      for (int c = 0; c < 1000 && sb.size() > 2; c++) tick();
      repeat (2) tick();
      check("reach_payload", sb.size(), 32'd2);
      check("frame_error_idle", {31'b0, frame_error}, 32'd0);
      pulse_start();
      check("frame_error_set", {31'b0, frame_error}, 32'd1);
      pulse_end();
      drain(1000, "frame5_drain");
      check("frame_error_sticky", {31'b0, frame_error}, 32'd1);

      // Frame 6: reset during header, then a clean frame
      expect_header();
      pulse_start();
      check("frame_error_cleared", {31'b0, frame_error}, 32'd0);
      repeat (20) tick();
      nreset = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_data", {24'b0, out_data}, 32'd0);
      check("mid_rst_flags", {28'b0, out_sof, out_eof, header_ebr_ren, quant_ebr_ren}, 32'd0);
      sb.delete();
      repeat (2) tick();
      nreset = 1'b1;
      tick();
      check("post_rst_valid", {31'b0, out_valid}, 32'd0);
      expect_header();
      expect_trailer();
      pulse_start();
      pulse_end();
      drain(1000, "frame6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
